// File: rtl/addsub64_seq_pkg.sv
// Shared definitions for the sliced add/subtract sequencer.
//   SLICE_W  : width of one adder slice
//   state_t  : sequencer FSM encoding
//   gp_carry : carry out of a block from its generate/propagate and carry in
package addsub_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic gp_carry(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

endpackage

// File: rtl/addsub64_seq_if.sv
// Operand/result handshake bundle for addsub64_seq.
//   in_valid/in_ready   : operation handshake (a, b, sub)
//   out_valid/out_ready : result handshake (s, c_out, ovf)
// master = upstream/consumer side, slave = the sequencer.
interface addsub64_seq_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/addsub64_seq_clax16.sv
// clax16: 16-bit carry lookahead adder built from four 4-bit lookahead groups.
//   a, b   : addends
//   c_in   : carry in
//   sum    : a + b + c_in (low 16 bits)
//   g_out  : block generate (carry out regardless of c_in)
//   p_out  : block propagate (carry out equals c_in)
module clax16
  import addsub_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        g_out,
  output logic        p_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [3:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      pg[i] = &p[4*i +: 4];
    end
    cg[0] = c_in;
    for (int i = 0; i < 3; i++) begin
      cg[i+1] = gp_carry(gg[i], pg[i], cg[i]);
    end
    for (int i = 0; i < 4; i++) begin
      c[4*i] = cg[i];
      for (int j = 1; j < 4; j++) begin
        c[4*i+j] = gp_carry(g[4*i+j-1], p[4*i+j-1], c[4*i+j-1]);
      end
    end
  end

  assign sum   = p ^ c;
  assign g_out = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0]);
  assign p_out = &pg;

endmodule

// File: rtl/addsub64_seq.sv
// addsub64_seq: multi-cycle add/subtract of W = 16*SLICES bit operands using a
// single 16-bit lookahead adder, one slice per clock, LSB slice first.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of addsub64_seq_if (operands in, result out)
// Subtraction is A + ~B + 1: B is inverted at capture and the carry is seeded
// with sub. c_out=1 on a subtract therefore means "no borrow".
module addsub64_seq
  import addsub_pkg::*;
#(
  parameter int SLICES = 4
) (
  input  logic           clk,
  input  logic           rst,
  addsub64_seq_if.slave  bus
);

  localparam int W     = SLICE_W * SLICES;
  localparam int IDX_W = $clog2(SLICES);

  state_t             state;
  state_t             state_nx;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [W-1:0]       s_r;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               ovf_r;
  logic               last_slice;
  logic               slice_carry;
  logic [SLICE_W-1:0] cla_a;
  logic [SLICE_W-1:0] cla_b;
  logic [SLICE_W-1:0] cla_sum;
  logic               cla_g;
  logic               cla_p;

  assign last_slice  = (idx == IDX_W'(SLICES - 1));
  assign cla_a       = a_r[SLICE_W*idx +: SLICE_W];
  assign cla_b       = b_r[SLICE_W*idx +: SLICE_W];
  assign slice_carry = gp_carry(cla_g, cla_p, carry);

  clax16 u_cla (
    .a     (cla_a),
    .b     (cla_b),
    .c_in  (carry),
    .sum   (cla_sum),
    .g_out (cla_g),
    .p_out (cla_p)
  );

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last_slice) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b ^ {W{bus.sub}};
            carry <= bus.sub;
            idx   <= '0;
          end
        end
        RUN: begin
          s_r[SLICE_W*idx +: SLICE_W] <= cla_sum;
          carry <= slice_carry;
          idx   <= idx + IDX_W'(1);
          // The MSB of the result is only known on the last slice, so
          // overflow is registered there rather than derived from s_r later.
          if (last_slice) begin
            ovf_r <= (a_r[W-1] == b_r[W-1]) & (cla_sum[SLICE_W-1] != a_r[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  // carry holds the final carry from the end of RUN until the next accept.
  assign bus.s     = s_r;
  assign bus.c_out = carry;
  assign bus.ovf   = ovf_r;

endmodule
